// File: rtl/wb_sequencer.sv
// Register-file write-back sequencer: ALU results take priority, colliding loads
// are buffered in an in-order FIFO, and a scoreboard tracks registers with loads in flight.
module wb_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [4:0]               ld_rd,
  input  logic [XLEN-1:0]          ld_data,
  input  logic                     iss_valid,
  input  logic                     iss_load,
  input  logic [4:0]               iss_rd,
  output logic [4:0]               rd,
  output logic [XLEN-1:0]          DataWr,
  output logic                     RUWr,
  output logic [31:0]              busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0] data_mem [DEPTH];
  logic [4:0]      rd_mem   [DEPTH];

  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [CW-1:0]   cnt_q,  cnt_d;
  logic [4:0]      rd_q,   rd_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            ruwr_q, ruwr_d;
  logic [31:0]     busy_q, busy_d;

  logic alu_take;
  logic fifo_ne;
  logic ld_use;
  logic push;
  logic pop;
  logic ld_wr;

  // ld_ready looks only at the registered count, so a same-cycle pop never frees a slot early.
  assign ld_ready = (cnt_q < CW'(DEPTH));
  assign alu_take = alu_valid && (alu_rd != 5'd0);
  assign fifo_ne  = (cnt_q != '0);
  assign ld_use   = ld_valid && ld_ready && (ld_rd != 5'd0);
  assign pop      = !alu_take && fifo_ne;
  assign push     = ld_use && (alu_take || fifo_ne);

  always_comb begin
    rd_d   = rd_q;
    data_d = data_q;
    ruwr_d = 1'b0;
    ld_wr  = 1'b0;
    if (alu_take) begin
      rd_d   = alu_rd;
      data_d = alu_data;
      ruwr_d = 1'b1;
    end else if (fifo_ne) begin
      rd_d   = rd_mem[rptr_q];
      data_d = data_mem[rptr_q];
      ruwr_d = 1'b1;
      ld_wr  = 1'b1;
    end else if (ld_use) begin
      rd_d   = ld_rd;
      data_d = ld_data;
      ruwr_d = 1'b1;
      ld_wr  = 1'b1;
    end
  end

  always_comb begin
    rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    cnt_d  = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Clear before set so a re-issue to the register being written keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (ld_wr) begin
      busy_d[rd_d] = 1'b0;
    end
    if (iss_valid && iss_load && (iss_rd != 5'd0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      rd_q   <= '0;
      data_q <= '0;
      ruwr_q <= 1'b0;
      busy_q <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
      data_q <= data_d;
      ruwr_q <= ruwr_d;
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wptr_q]   <= ld_rd;
      data_mem[wptr_q] <= ld_data;
    end
  end

  assign rd         = rd_q;
  assign DataWr     = data_q;
  assign RUWr       = ruwr_q;
  assign busy       = busy_q;
  assign fifo_count = cnt_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Bench for wb_sequencer: a reference model predicts each write-port event into a
// queue at drive time; the queue is popped when the DUT registers a write.
module tb_wb_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            iss_valid;
  logic            iss_load;
  logic [4:0]      iss_rd;
  logic [4:0]      rd;
  logic [XLEN-1:0] DataWr;
  logic            RUWr;
  logic [31:0]     busy;
  logic [2:0]      fifo_count;

  wb_sequencer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .iss_valid(iss_valid), .iss_load(iss_load), .iss_rd(iss_rd),
    .rd(rd), .DataWr(DataWr), .RUWr(RUWr), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [36:0] exp_q  [$];
  logic [36:0] m_fifo [$];
  logic [31:0] m_busy = '0;
  logic [36:0] m_last = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lr, input logic [31:0] ldd,
                      input logic iv, input logic il, input logic [4:0] ir);
    logic        mready, luse, lwr;
    logic [4:0]  wrd;
    logic [36:0] w;
    alu_valid = av; alu_rd = ar; alu_data = ad;
    ld_valid  = lv; ld_rd  = lr; ld_data  = ldd;
    iss_valid = iv; iss_load = il; iss_rd = ir;
    #1;
    mready = (m_fifo.size() < DEPTH);
    check_eq("ld_ready", {63'd0, ld_ready}, {63'd0, mready});
    luse = lv && mready && (lr != 5'd0);
    lwr  = 1'b0;
    wrd  = 5'd0;
    if (av && ar != 5'd0) begin
      exp_q.push_back({ar, ad});
      if (luse) m_fifo.push_back({lr, ldd});
    end else if (m_fifo.size() != 0) begin
      w = m_fifo.pop_front();
      exp_q.push_back(w);
      lwr = 1'b1;
      wrd = w[36:32];
      if (luse) m_fifo.push_back({lr, ldd});
    end else if (luse) begin
      exp_q.push_back({lr, ldd});
      lwr = 1'b1;
      wrd = lr;
    end
    if (lwr) m_busy[wrd] = 1'b0;
    if (iv && il && ir != 5'd0) m_busy[ir] = 1'b1;
    @(posedge clk);
    #1;
    check_eq("RUWr", {63'd0, RUWr}, {63'd0, (exp_q.size() != 0)});
    if (exp_q.size() != 0) begin
      w = exp_q.pop_front();
      m_last = w;
      if (RUWr) check_eq("write", {27'd0, rd, DataWr}, {27'd0, w});
    end else begin
      check_eq("hold", {27'd0, rd, DataWr}, {27'd0, m_last});
    end
    check_eq("fifo_count", {61'd0, fifo_count}, 64'(m_fifo.size()));
    check_eq("busy", {32'd0, busy}, {32'd0, m_busy});
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    iss_valid = 0; iss_load = 0; iss_rd = 0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_RUWr", {63'd0, RUWr}, 64'd0);
    check_eq("rst_ld_ready", {63'd0, ld_ready}, 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Bypass
    step(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    check_eq("t2_rd", {59'd0, rd}, 64'd5);
    check_eq("t2_data", {32'd0, DataWr}, 64'hDEADBEEF);
    idle();

    // ALU/load collision
    step(1, 3, 32'h11, 1, 7, 32'h22, 0, 0, 0);
    check_eq("t3_rd_alu", {59'd0, rd}, 64'd3);
    check_eq("t3_count", {61'd0, fifo_count}, 64'd1);
    idle();
    check_eq("t3_rd_ld", {59'd0, rd}, 64'd7);
    check_eq("t3_data_ld", {32'd0, DataWr}, 64'h22);

    // FIFO full under a long ALU burst
    for (int i = 0; i < 6; i++)
      step(1, 5'(10 + i), 32'(32'hA0 + i), 1, 5'(20 + i), 32'(32'h100 + i), 0, 0, 0);
    check_eq("t4_ready_full", {63'd0, ld_ready}, 64'd0);
    check_eq("t4_count_full", {61'd0, fifo_count}, 64'd4);
    for (int i = 0; i < 4; i++) begin
      idle();
      check_eq("t4_drain_rd", {59'd0, rd}, 64'(20 + i));
    end
    check_eq("t4_ready_after", {63'd0, ld_ready}, 64'd1);

    // Scoreboard set / clear / set-wins
    step(0, 0, 0, 0, 0, 0, 1, 1, 9);
    check_eq("t5_set", {63'd0, busy[9]}, 64'd1);
    step(0, 0, 0, 1, 9, 32'h99, 0, 0, 0);
    check_eq("t5_clear", {63'd0, busy[9]}, 64'd0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 9);
    step(0, 0, 0, 1, 9, 32'h98, 1, 1, 9);
    check_eq("t5_set_wins", {63'd0, busy[9]}, 64'd1);
    step(0, 0, 0, 1, 9, 32'h97, 0, 0, 0);
    check_eq("t5_clear2", {63'd0, busy[9]}, 64'd0);

    // x0 destinations
    step(1, 0, 32'hAA, 1, 0, 32'hBB, 1, 1, 0);
    check_eq("t6_ruwr", {63'd0, RUWr}, 64'd0);
    check_eq("t6_busy0", {63'd0, busy[0]}, 64'd0);
    step(1, 4, 32'h44, 1, 0, 32'hCC, 0, 0, 0);
    check_eq("t6_no_push", {61'd0, fifo_count}, 64'd0);

    // Asynchronous reset with three loads buffered
    for (int i = 0; i < 3; i++)
      step(1, 5'(1 + i), 32'(i), 1, 5'(12 + i), 32'(32'h500 + i), 1, 1, 5'(12 + i));
    check_eq("t1_pre_count", {61'd0, fifo_count}, 64'd3);
    alu_valid = 0; ld_valid = 0; iss_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("t1_RUWr", {63'd0, RUWr}, 64'd0);
    check_eq("t1_rd", {59'd0, rd}, 64'd0);
    check_eq("t1_data", {32'd0, DataWr}, 64'd0);
    check_eq("t1_busy", {32'd0, busy}, 64'd0);
    check_eq("t1_count", {61'd0, fifo_count}, 64'd0);
    check_eq("t1_ready", {63'd0, ld_ready}, 64'd1);
    m_fifo.delete(); exp_q.delete(); m_busy = '0; m_last = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 99) < 45), 5'($urandom_range(0, 31)), $urandom(),
           ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 31)), $urandom(),
           ($urandom_range(0, 99) < 50), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    repeat (DEPTH + 1) idle();
    check_eq("final_count", {61'd0, fifo_count}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
